// File: rtl/sysid_pkg.sv
// Shared types and constants for the sysid self-check read master.
package sysid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ID_REQ,
    ID_WAIT,
    TS_REQ,
    TS_WAIT,
    FINISH
  } sysid_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_ID = 32'h0000_0000;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1462218947;

endpackage

// File: rtl/sysid_timeout_counter.sv
// Per-transaction watchdog for the sysid read master.
// Only present when SYSID_CHECK_TIMEOUT_EN is defined.
`ifdef SYSID_CHECK_TIMEOUT_EN
module sysid_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Saturates at LAST so a stalled transaction keeps expired asserted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule
`endif

// File: rtl/sysid_checker_master.sv
// Avalon-MM read master: reads sysid ID (addr 0) and timestamp (addr 1), compares to build-time values.
// Optional per-transaction timeout enabled with SYSID_CHECK_TIMEOUT_EN.
module sysid_checker_master
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TS,
  parameter int          TIMEOUT_CYCLES     = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  sysid_state_t state;
  logic         start_acc;
  logic         tmo_hit;
  logic         id_cap_p0;
  logic         ts_cap_p0;
  logic         tmo_p0;

  assign start_acc = (state == IDLE) && start;

`ifdef SYSID_CHECK_TIMEOUT_EN
  logic tmo_clear;
  logic tmo_en;

  // Counter restarts whenever a new read command is about to be issued.
  assign tmo_clear = start_acc || ((state == ID_WAIT) && avm_readdatavalid);
  assign tmo_en    = (state == ID_REQ) || (state == ID_WAIT) ||
                     (state == TS_REQ) || (state == TS_WAIT);

  sysid_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (tmo_hit)
  );
`else
  localparam int tmo_cycles_unused = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  // Stage p0: bus FSM, command and data capture
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      avm_read    <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      id_cap_p0   <= 1'b0;
      ts_cap_p0   <= 1'b0;
      tmo_p0      <= 1'b0;
    end else begin
      done      <= 1'b0;
      id_cap_p0 <= 1'b0;
      ts_cap_p0 <= 1'b0;
      tmo_p0    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= ID_REQ;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_ID;
            busy        <= 1'b1;
          end
        end
        ID_REQ: begin
          if (!avm_waitrequest) begin
            state    <= ID_WAIT;
            avm_read <= 1'b0;
          end else if (tmo_hit) begin
            state    <= FINISH;
            avm_read <= 1'b0;
            tmo_p0   <= 1'b1;
          end
        end
        ID_WAIT: begin
          if (avm_readdatavalid) begin
            id_value    <= avm_readdata;
            id_cap_p0   <= 1'b1;
            state       <= TS_REQ;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_TS;
          end else if (tmo_hit) begin
            state  <= FINISH;
            tmo_p0 <= 1'b1;
          end
        end
        TS_REQ: begin
          if (!avm_waitrequest) begin
            state    <= TS_WAIT;
            avm_read <= 1'b0;
          end else if (tmo_hit) begin
            state    <= FINISH;
            avm_read <= 1'b0;
            tmo_p0   <= 1'b1;
          end
        end
        TS_WAIT: begin
          if (avm_readdatavalid) begin
            ts_value  <= avm_readdata;
            ts_cap_p0 <= 1'b1;
            state     <= FINISH;
          end else if (tmo_hit) begin
            state  <= FINISH;
            tmo_p0 <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          avm_read <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Stage p1: compare captured words, latch status until the next start
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_ok   <= 1'b0;
      ts_ok   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (start_acc) begin
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
        timeout <= 1'b0;
      end
      if (id_cap_p0) id_ok <= (id_value == EXPECTED_ID);
      if (ts_cap_p0) ts_ok <= (ts_value == EXPECTED_TIMESTAMP);
      if (tmo_p0)    timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sysid_checker_master.sv
// Scoreboard bench for sysid_checker_master with a behavioural Avalon slave and random stimulus.
module tb_sysid_checker_master;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1462218947;
  localparam int          TMO    = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  sysid_checker_master #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (TMO)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_readdata      (avm_readdata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .id_ok             (id_ok),
    .ts_ok             (ts_ok),
    .timeout           (timeout),
    .id_value          (id_value),
    .ts_value          (ts_value)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave configuration, written by the stimulus process only
  int          cfg_wait = 0;
  int          cfg_lat = 1;
  bit          cfg_stall_forever = 1'b0;
  logic [31:0] mem_id = EXP_ID;
  logic [31:0] mem_ts = EXP_TS;
  int          stray_req_n = 0;
  int          acc_cnt = 0;

  typedef struct {
    logic [31:0] idv;
    logic [31:0] tsv;
    logic        iok;
    logic        tok;
    logic        to;
    int          dcyc;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural slave: waits cfg_wait cycles per command, answers cfg_lat cycles after acceptance
  initial begin : slave
    int   stall_left;
    int   resp_cnt;
    logic resp_addr;
    bit   stalled_prev;
    logic stalled_addr;
    int   stray_done;
    stall_left = -1; resp_cnt = 0; resp_addr = 1'b0;
    stalled_prev = 1'b0; stalled_addr = 1'b0; stray_done = 0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    forever begin
      @(negedge clock);
      avm_readdatavalid = 1'b0;
      avm_readdata = $urandom;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = resp_addr ? mem_ts : mem_id;
        end
      end else if (stray_done != stray_req_n) begin
        stray_done++;
        avm_readdatavalid = 1'b1;
        avm_readdata = 32'hDEAD_BEEF;
      end
      if (stalled_prev && !cfg_stall_forever) begin
        chk("cmd_hold_read", {31'd0, avm_read}, 32'd1);
        chk("cmd_hold_addr", {31'd0, avm_address}, {31'd0, stalled_addr});
      end
      stalled_prev = 1'b0;
      if (cfg_stall_forever) begin
        avm_waitrequest = 1'b1;
      end else if (avm_read) begin
        if (stall_left < 0) stall_left = cfg_wait;
        if (stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
          stalled_prev = 1'b1;
          stalled_addr = avm_address;
        end else begin
          avm_waitrequest = 1'b0;
          stall_left = -1;
          resp_cnt = cfg_lat;
          resp_addr = avm_address;
          chk("read_addr", {31'd0, avm_address}, 32'(acc_cnt % 2));
          acc_cnt++;
        end
      end else begin
        avm_waitrequest = 1'b0;
      end
    end
  end

  // Monitor: checks reset values, pops the scoreboard on every done pulse
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        exp_q.delete();
        chk("rst_avm_read", {31'd0, avm_read}, 32'd0);
        chk("rst_avm_address", {31'd0, avm_address}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
        chk("rst_id_value", id_value, 32'd0);
        chk("rst_ts_value", ts_value, 32'd0);
      end else if (done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", {31'd0, done}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.dcyc));
          chk("id_value", id_value, e.idv);
          chk("ts_value", ts_value, e.tsv);
          chk("id_ok", {31'd0, id_ok}, {31'd0, e.iok});
          chk("ts_ok", {31'd0, ts_ok}, {31'd0, e.tok});
          chk("timeout", {31'd0, timeout}, {31'd0, e.to});
          chk("busy_at_done", {31'd0, busy}, 32'd0);
        end
      end
    end
  end

  logic [31:0] last_id = '0;
  logic [31:0] last_ts = '0;
  logic        last_iok = 1'b0;
  logic        last_tok = 1'b0;

  // Issues one check from a negedge; expected result derived from the slave settings.
  task automatic run_check(input int w, input int lat, input logic [31:0] idd,
                           input logic [31:0] tsd, input bit stall_forever,
                           input bit extra_start);
    exp_t e;
    int   n, t0, base;
    cfg_wait = w; cfg_lat = lat; mem_id = idd; mem_ts = tsd;
    cfg_stall_forever = stall_forever;
    base = acc_cnt;
    n = cyc;
    if (stall_forever) begin
      e.idv = last_id; e.tsv = last_ts; e.iok = 1'b0; e.tok = 1'b0; e.to = 1'b1;
      e.dcyc = n + TMO + 2;
      last_iok = 1'b0; last_tok = 1'b0;
    end else begin
      e.idv = idd; e.tsv = tsd; e.iok = (idd == EXP_ID); e.tok = (tsd == EXP_TS);
      e.to = 1'b0;
      e.dcyc = n + 6 + (w + lat - 1) + (w + lat - 1);
      last_id = idd; last_ts = tsd; last_iok = e.iok; last_tok = e.tok;
    end
    exp_q.push_back(e);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("read_at_n1", {31'd0, avm_read}, 32'd1);
    chk("busy_at_n1", {31'd0, busy}, 32'd1);
    t0 = cyc;
    while (!done && cyc < t0 + 200) begin
      start = (extra_start && cyc == n + 3) ? 1'b1 : 1'b0;
      @(negedge clock);
    end
    start = 1'b0;
    if (!done) chk("done_seen", 32'd0, 32'd1);
    repeat (2) @(negedge clock);
    chk("read_idle", {31'd0, avm_read}, 32'd0);
    chk("reads_issued", 32'(acc_cnt - base), stall_forever ? 32'd0 : 32'd2);
    cfg_stall_forever = 1'b0;
  endtask

  initial begin : stim
    int base, t0;
    logic [31:0] rid, rts;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    while (cyc < 10) @(negedge clock);

    // Zero-wait, latency-1 slave with matching data
    run_check(0, 1, EXP_ID, EXP_TS, 1'b0, 1'b0);
    // Three stall cycles per command, latency 2
    run_check(3, 2, EXP_ID, EXP_TS, 1'b0, 1'b0);
    // Wrong ID word, timestamp still read
    run_check(0, 1, 32'h0000_0001, EXP_TS, 1'b0, 1'b0);

`ifdef SYSID_CHECK_TIMEOUT_EN
    // Slave never accepts the command
    run_check(0, 1, EXP_ID, EXP_TS, 1'b1, 1'b0);
`endif

    // Reset during TS_WAIT with a response still in flight
    cfg_wait = 0; cfg_lat = 4; mem_id = EXP_ID; mem_ts = EXP_TS;
    base = acc_cnt;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    t0 = cyc;
    while (acc_cnt < base + 2 && cyc < t0 + 50) @(negedge clock);
    chk("ts_read_accepted", 32'(acc_cnt - base), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_read", {31'd0, avm_read}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_id_value", id_value, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    chk("late_rdv_id_value", id_value, 32'd0);
    chk("late_rdv_ts_value", ts_value, 32'd0);
    chk("late_rdv_busy", {31'd0, busy}, 32'd0);
    chk("late_rdv_flags", {30'd0, id_ok, ts_ok}, 32'd0);
    last_id = '0; last_ts = '0;
    run_check(0, 1, EXP_ID, EXP_TS, 1'b0, 1'b0);

    // Second start while busy, then a stray readdatavalid in IDLE
    run_check(1, 2, EXP_ID, 32'h1234_5678, 1'b0, 1'b1);
    base = acc_cnt;
    repeat (15) @(negedge clock);
    chk("no_extra_reads", 32'(acc_cnt - base), 32'd0);
    stray_req_n++;
    repeat (5) @(negedge clock);
    chk("stray_id_value", id_value, last_id);
    chk("stray_ts_value", ts_value, last_ts);
    chk("stray_flags", {30'd0, id_ok, ts_ok}, {30'd0, last_iok, last_tok});
    chk("stray_busy", {31'd0, busy}, 32'd0);

    // Randomized slave timing and data
    for (int i = 0; i < 8; i++) begin
      rid = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
      rts = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
      run_check($urandom_range(0, 3), $urandom_range(1, 3), rid, rts, 1'b0, 1'b0);
    end

    repeat (5) @(negedge clock);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
